// File: rtl/pong_ball_engine.sv
`timescale 1ns/1ps
// pong_ball_engine: per-side ball physics, rally state machine, score keeping
// and valid/ready ball hand-off toward the opponent board.
module pong_ball_engine #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_W      = 20,
  parameter int X_STEP      = 10,
  parameter int BASE_TICKS  = 270000,
  parameter int GRAV_PERIOD = 4,
  parameter int SERVE_VY    = -3,
  parameter int MAX_SCORE   = 7,
  parameter int SIDE        = 0
) (
  input  logic              clk_25MHZ,
  input  logic              reset_n,
  input  logic              game_start,
  input  logic              collision_detected,
  input  logic [9:0]        estimated_speed,
  input  logic              rx_valid,
  input  logic [9:0]        rx_y,
  input  logic signed [7:0] rx_vy,
  input  logic [1:0]        rx_grav,
  input  logic [1:0]        rx_level,
  input  logic              rx_point,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [9:0]        tx_y,
  output logic signed [7:0] tx_vy,
  output logic [1:0]        tx_grav,
  output logic [1:0]        tx_level,
  output logic [9:0]        ball_x,
  output logic [9:0]        ball_y,
  output logic              moving_in,
  output logic              moving_out,
  output logic              point_lost,
  output logic [3:0]        score_me,
  output logic [3:0]        score_opp,
  output logic              game_over,
  output logic              winner,
  output logic [2:0]        dbg_state
);
  function automatic int per(input int k);
    return (BASE_TICKS / k < 1) ? 1 : BASE_TICKS / k;
  endfunction

  localparam int                 X_MAX   = H_RES - BALL_W;
  localparam int                 TW      = $clog2(BASE_TICKS + 1);
  localparam logic [9:0]         X_OWN   = (SIDE == 0) ? 10'd0 : 10'(X_MAX);
  localparam logic [9:0]         X_FAR   = (SIDE == 0) ? 10'(X_MAX) : 10'd0;
  localparam logic [9:0]         XS      = 10'(X_STEP);
  localparam logic [9:0]         Y_MID   = 10'(V_RES / 2);
  localparam logic [9:0]         Y_BOT10 = 10'(V_RES - 1);
  localparam logic signed [11:0] Y_BOT   = 12'(V_RES - 1);
  localparam logic signed [7:0]  SERVE_V = 8'(SERVE_VY);
  localparam logic [1:0]         G_LAST  = 2'(GRAV_PERIOD - 1);
  localparam logic [3:0]         MAX_S   = 4'(MAX_SCORE);
  localparam logic [TW-1:0]      L1      = TW'(per(1) - 1);
  localparam logic [TW-1:0]      L2      = TW'(per(2) - 1);
  localparam logic [TW-1:0]      L3      = TW'(per(3) - 1);
  localparam logic [TW-1:0]      L4      = TW'(per(4) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN_OUT, S_RUN_IN, S_HANDOFF, S_WAIT, S_MISS, S_SCORE, S_OVER
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic signed [7:0]  vy_q, vy_d;
  logic [1:0]         grav_q, grav_d, lvl_q, lvl_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [3:0]         score_me_q, score_me_d, score_opp_q, score_opp_d;
  logic               winner_q, winner_d, tx_valid_q, tx_valid_d;
  logic [9:0]         tx_y_q, tx_y_d;
  logic signed [7:0]  tx_vy_q, tx_vy_d;
  logic [1:0]         tx_grav_q, tx_grav_d, tx_lvl_q, tx_lvl_d;

  logic [TW-1:0]      tick_last;
  logic [9:0]         target, x_step, y_step;
  logic [10:0]        x_up;
  logic signed [11:0] y_sum;
  logic signed [7:0]  vy_g, vy_step;
  logic [1:0]         grav_step, speed_lvl;
  logic               step_en, load_rx;

  // One physics step: x toward the current target edge, y with bounce, gravity.
  always_comb begin
    case (lvl_q)
      2'd0:    tick_last = L1;
      2'd1:    tick_last = L2;
      2'd2:    tick_last = L3;
      default: tick_last = L4;
    endcase
    target = (state_q == S_RUN_OUT) ? X_FAR : X_OWN;
    x_up   = {1'b0, x_q} + {1'b0, XS};
    if (target > x_q) x_step = (x_up >= {1'b0, target}) ? target : x_up[9:0];
    else              x_step = ((x_q - target) <= XS) ? target : x_q - XS;
    y_sum = $signed({2'b00, y_q}) + $signed({{4{vy_q[7]}}, vy_q});
    if (grav_q == G_LAST) begin
      vy_g      = (vy_q == 8'sd127) ? vy_q : vy_q + 8'sd1;
      grav_step = 2'd0;
    end else begin
      vy_g      = vy_q;
      grav_step = grav_q + 2'd1;
    end
    if (y_sum >= Y_BOT) begin
      y_step  = Y_BOT10;
      vy_step = -vy_g;
    end else if (y_sum <= 12'sd0) begin
      y_step  = 10'd0;
      vy_step = -vy_g;
    end else begin
      y_step  = y_sum[9:0];
      vy_step = vy_g;
    end
    if (estimated_speed == 10'd0)       speed_lvl = 2'd0;
    else if (estimated_speed >= 10'd4)  speed_lvl = 2'd3;
    else                                speed_lvl = estimated_speed[1:0] - 2'd1;
  end

  // Hand-off: tx_valid stays high with tx_* frozen until the cycle tx_ready
  // is seen high; the transfer completes on that edge and tx_valid drops.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    vy_d        = vy_q;
    grav_d      = grav_q;
    lvl_d       = lvl_q;
    tick_d      = tick_q;
    score_me_d  = score_me_q;
    score_opp_d = score_opp_q;
    winner_d    = winner_q;
    tx_valid_d  = tx_valid_q;
    tx_y_d      = tx_y_q;
    tx_vy_d     = tx_vy_q;
    tx_grav_d   = tx_grav_q;
    tx_lvl_d    = tx_lvl_q;
    step_en     = 1'b0;
    load_rx     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (game_start) begin
          state_d = S_RUN_OUT;
          x_d     = X_OWN;
          y_d     = Y_MID;
          vy_d    = SERVE_V;
          grav_d  = 2'd0;
          lvl_d   = 2'd0;
        end else if (rx_valid) begin
          load_rx = 1'b1;
        end
      end
      S_RUN_OUT: begin
        if (x_q == X_FAR) begin
          state_d    = S_HANDOFF;
          tx_valid_d = 1'b1;
          tx_y_d     = y_q;
          tx_vy_d    = vy_q;
          tx_grav_d  = grav_q;
          tx_lvl_d   = lvl_q;
        end else begin
          step_en = 1'b1;
        end
      end
      S_RUN_IN: begin
        if (collision_detected) begin
          state_d = S_RUN_OUT;
          lvl_d   = speed_lvl;
        end else if (x_q == X_OWN) begin
          state_d = S_MISS;
        end else begin
          step_en = 1'b1;
        end
      end
      S_HANDOFF: begin
        if (tx_ready) begin
          state_d    = S_WAIT;
          tx_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (rx_point)      state_d = S_SCORE;
        else if (rx_valid) load_rx = 1'b1;
      end
      S_MISS: begin
        score_opp_d = score_opp_q + 4'd1;
        winner_d    = 1'b0;
        state_d     = (score_opp_d == MAX_S) ? S_OVER : S_IDLE;
      end
      S_SCORE: begin
        score_me_d = score_me_q + 4'd1;
        winner_d   = (score_me_d == MAX_S);
        state_d    = (score_me_d == MAX_S) ? S_OVER : S_IDLE;
      end
      S_OVER: begin
        if (game_start) begin
          state_d     = S_IDLE;
          score_me_d  = 4'd0;
          score_opp_d = 4'd0;
          winner_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_rx) begin
      state_d = S_RUN_IN;
      x_d     = X_FAR;
      y_d     = rx_y;
      vy_d    = rx_vy;
      grav_d  = rx_grav;
      lvl_d   = rx_level;
    end
    if (step_en) begin
      if (tick_q == tick_last) begin
        x_d    = x_step;
        y_d    = y_step;
        vy_d   = vy_step;
        grav_d = grav_step;
        tick_d = '0;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
    if (state_d != state_q) tick_d = '0;
  end

  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      x_q         <= X_OWN;
      y_q         <= Y_MID;
      vy_q        <= SERVE_V;
      grav_q      <= 2'd0;
      lvl_q       <= 2'd0;
      tick_q      <= '0;
      score_me_q  <= 4'd0;
      score_opp_q <= 4'd0;
      winner_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_y_q      <= 10'd0;
      tx_vy_q     <= 8'sd0;
      tx_grav_q   <= 2'd0;
      tx_lvl_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      grav_q      <= grav_d;
      lvl_q       <= lvl_d;
      tick_q      <= tick_d;
      score_me_q  <= score_me_d;
      score_opp_q <= score_opp_d;
      winner_q    <= winner_d;
      tx_valid_q  <= tx_valid_d;
      tx_y_q      <= tx_y_d;
      tx_vy_q     <= tx_vy_d;
      tx_grav_q   <= tx_grav_d;
      tx_lvl_q    <= tx_lvl_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_y       = tx_y_q;
  assign tx_vy      = tx_vy_q;
  assign tx_grav    = tx_grav_q;
  assign tx_level   = tx_lvl_q;
  assign ball_x     = x_q;
  assign ball_y     = y_q;
  assign moving_in  = (state_q == S_RUN_IN);
  assign moving_out = (state_q == S_RUN_OUT);
  assign point_lost = (state_q == S_MISS);
  assign score_me   = score_me_q;
  assign score_opp  = score_opp_q;
  assign game_over  = (state_q == S_OVER);
  assign winner     = winner_q;
  assign dbg_state  = state_q;
endmodule

// File: doc/pong_ball_engine.md
# pong_ball_engine

Parametrised ball-physics and rally controller for the two-board pong game. It replaces the fixed 320/640-pixel single-side controller with a generic engine. Side, screen size, step, gravity and speed table are all parameters. It adds score keeping, a match-end condition, clamped edge stepping and a valid/ready ball hand-off. It sits between the paddle collision/speed detector and the inter-board I2C link logic.

## Interface
- `H_RES`, 640: screen width (px)
- `V_RES`, 480: screen height (px)
- `BALL_W`, 20: ball width; `X_MAX = H_RES-BALL_W`
- `X_STEP`, 10: x pixels per physics step
- `BASE_TICKS`, 270000: cycles per step at level 1; level k period `P_k = max(1, BASE_TICKS/k)`, k=1..4, elaboration constants
- `GRAV_PERIOD`, 4: steps per +1 added to vy
- `SERVE_VY`, -3: serve vertical velocity
- `MAX_SCORE`, 7: points ending the match
- `SIDE`, 0: 0 = own paddle at x=0, hand-off edge at X_MAX; 1 = mirrored
- `clk_25MHZ  in  1  system clock`
- `reset_n  in  1  reset; **one clock; reset is asynchronous and active-low**`
- `game_start  in  1  pulse: serve (IDLE) / new match (OVER)`
- `collision_detected  in  1  paddle hit`
- `estimated_speed  in  10  paddle speed`
- `rx_valid  in  1  ball arriving from opponent (1-cycle pulse)`
- `rx_y  in  10`, `rx_vy  in  8 signed`, `rx_grav  in  2`, `rx_level  in  2`: arriving ball state
- `rx_point  in  1  pulse: opponent missed`
- `tx_valid  out  1`, `tx_ready  in  1`: hand-off handshake
- `tx_y  out  10`, `tx_vy  out  8 signed`, `tx_grav  out  2`, `tx_level  out  2`: outgoing ball state; level field = k-1
- `ball_x  out  10`, `ball_y  out  10`: ball position
- `moving_in  out  1  state RUN_IN`, `moving_out  out  1  state RUN_OUT`
- `point_lost  out  1  1-cycle pulse on own miss`
- `score_me  out  4`, `score_opp  out  4`: scores
- `game_over  out  1  state OVER`
- `winner  out  1  1 = us; valid while game_over`

## Operation
- Edges: OWN = 0 (SIDE=0) or X_MAX (SIDE=1); FAR = the other edge. "In" means toward OWN.
- States:
  - IDLE: game_start → RUN_OUT, x=OWN, y=V_RES/2, vy=SERVE_VY, grav=0, k=1. rx_valid → RUN_IN, x=FAR, load rx fields, k=rx_level+1. game_start has priority.
  - RUN_OUT: x==FAR → HANDOFF; otherwise step.
  - RUN_IN: collision_detected → RUN_OUT, k=clamp(estimated_speed,1,4), tick=0. Else x==OWN → MISS. Else step. Collision wins over edge.
  - HANDOFF: tx_valid=1; tx_* frozen. tx_valid&tx_ready → WAIT_REMOTE.
  - WAIT_REMOTE: ball_x/ball_y hold. rx_point → SCORE. Else rx_valid → RUN_IN as in IDLE. rx_point wins.
  - MISS (1 cycle): point_lost=1, score_opp+1; then OVER if score_opp==MAX_SCORE, else IDLE.
  - SCORE (1 cycle): score_me+1; then OVER (winner=1) if score_me==MAX_SCORE, else IDLE.
  - OVER: game_start clears scores and winner → IDLE. All other inputs ignored.
- Inputs not listed for a state are ignored; no input is ever queued.
- Step, done when tick==P_k-1 (tick then resets; otherwise tick+1):
  - x moves X_STEP toward target, clamped to the edge.
  - y' = y+vy, computed signed 12-bit.
  - If grav==GRAV_PERIOD-1: vy+=1 (saturating at 127), grav=0; else grav+1.
  - If y' ≥ V_RES-1: y=V_RES-1, vy=-vy_new. If y' ≤ 0: y=0, vy=-vy_new.
- tick clears on every state entry.

## Timing
- Reset values:
  - state IDLE, ball_x=OWN, ball_y=V_RES/2
  - vy=SERVE_VY, grav=0, k=1, tick=0
  - all flags, scores, tx_valid and point_lost 0; tx_* 0
- Edge checks use the registered x and take one cycle, with no step in that cycle.
- First step lands P_k cycles after entering RUN state.
- tx_valid rises the cycle after the FAR-edge detection. It falls the cycle after the handshake.
- rx to RUN_IN: 1 cycle. Miss to point_lost: 1 cycle.
- Reset mid-operation drops tx_valid immediately (asynchronous) and abandons the rally; scores are lost.

## Test plan
Defaults for all scenarios: H_RES=64, V_RES=48, BALL_W=4, X_STEP=10, BASE_TICKS=8, GRAV_PERIOD=4, MAX_SCORE=3, SIDE=0.
1. Serve. Pulse game_start → x 0,10,…,60, one step every 8 cycles; y 21,18,15,12,10,8. Then tx_valid=1 with tx_y=8, tx_vy=-2, tx_grav=2, tx_level=0. Hold tx_ready=0 for 5 cycles → fields stable; tx_ready=1 → tx_valid=0 next cycle.
2. Return hit. In WAIT_REMOTE, rx_valid with y=30, vy=0, level 0 → RUN_IN at x=60. Assert collision with estimated_speed=2 → RUN_OUT; steps every 4 cycles; later tx_level=1.
3. Miss. Same rx, no collision → x reaches 0 → point_lost for 1 cycle, score_opp=1, IDLE.
4. Floor bounce. rx_y=46, rx_vy=+5 → first step y=47, vy=-5.
5. Match end. Three misses → game_over=1, winner=0. Three rx_point instead → winner=1. game_start → scores 0, IDLE.
6. Corners:
   - collision_detected at x==0 → RUN_OUT, no point.
   - rx_point together with rx_valid → SCORE.
   - reset_n low during HANDOFF → tx_valid 0 immediately.
